// File: rtl/fetch_pkg.sv
// Shared defaults, state encoding and latency-counter type for the
// instruction-fetch front end.
package fetch_pkg;
   localparam int unsigned FETCH_ADDR_W = 12;
   localparam int unsigned FETCH_DATA_W = 32;
   localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = '0;
   localparam int unsigned LAT_CNT_W = 3;

   typedef enum logic {
      S_WAIT,
      S_HOLD
   } fetch_state_e;

   typedef logic [LAT_CNT_W-1:0] lat_cnt_t;
endpackage

// File: rtl/imem_fetch_unit_if.sv
// Fetch-side bus: imem address/data plus the decode valid/ready handshake
// and the redirect request.
interface imem_fetch_unit_if
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_W = FETCH_ADDR_W,
   parameter int unsigned DATA_W = FETCH_DATA_W
);
   logic [ADDR_W-1:0] address_imem;
   logic [DATA_W-1:0] q_imem;
   logic [DATA_W-1:0] insn;
   logic [ADDR_W-1:0] insn_pc;
   logic [ADDR_W-1:0] insn_pc_plus1;
   logic              insn_valid;
   logic              insn_ready;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;

   modport master (
      output address_imem,
      input  q_imem,
      output insn,
      output insn_pc,
      output insn_pc_plus1,
      output insn_valid,
      input  insn_ready,
      input  redirect_valid,
      input  redirect_pc
   );

   modport slave (
      input  address_imem,
      output q_imem,
      input  insn,
      input  insn_pc,
      input  insn_pc_plus1,
      input  insn_valid,
      output insn_ready,
      output redirect_valid,
      output redirect_pc
   );
endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter / imem address register: load on redirect, increment
// (modulo 2^ADDR_W) on handshake, RESET_PC on reset.
module fetch_pc_reg
   import fetch_pkg::*;
#(
   parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_pc,
   input  logic              inc,
   output logic [ADDR_W-1:0] pc_q
);
   logic [ADDR_W-1:0] pc_d;

   // Load outranks increment so a redirect coinciding with a handshake wins.
   always_comb begin
      pc_d = pc_q;
      if (load) begin
         pc_d = load_pc;
      end else if (inc) begin
         pc_d = pc_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end
endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction-fetch front end: waits IMEM_LATENCY edges per address, captures
// q_imem and presents it to decode; redirects discard any pending fetch.
module imem_fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned       ADDR_W       = FETCH_ADDR_W,
   parameter int unsigned       DATA_W       = FETCH_DATA_W,
   parameter int unsigned       IMEM_LATENCY = 1,
   parameter logic [ADDR_W-1:0] RESET_PC     = '0
) (
   input  logic                clock,
   input  logic                reset,
   imem_fetch_unit_if.master   bus,
   output logic [31:0]         insn_count
);
   localparam lat_cnt_t LAST_LAT = lat_cnt_t'(IMEM_LATENCY - 1);

   fetch_state_e      state_q, state_d;
   lat_cnt_t          lat_cnt_q, lat_cnt_d;
   logic [DATA_W-1:0] insn_q, insn_d;
   logic [ADDR_W-1:0] insn_pc_q, insn_pc_d;
   logic              insn_valid_q, insn_valid_d;
   logic [31:0]       insn_count_q, insn_count_d;
   logic [ADDR_W-1:0] pc;
   logic              pc_inc;

   fetch_pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clock   (clock),
      .reset   (reset),
      .load    (bus.redirect_valid),
      .load_pc (bus.redirect_pc),
      .inc     (pc_inc),
      .pc_q    (pc)
   );

   always_comb begin
      state_d      = state_q;
      lat_cnt_d    = lat_cnt_q;
      insn_d       = insn_q;
      insn_pc_d    = insn_pc_q;
      insn_valid_d = insn_valid_q;
      insn_count_d = insn_count_q;
      pc_inc       = 1'b0;

      case (state_q)
         S_WAIT: begin
            if (lat_cnt_q == LAST_LAT) begin
               insn_d       = bus.q_imem;
               insn_pc_d    = pc;
               insn_valid_d = 1'b1;
               lat_cnt_d    = '0;
               state_d      = S_HOLD;
            end else begin
               lat_cnt_d = lat_cnt_q + lat_cnt_t'(1);
            end
         end
         S_HOLD: begin
            if (bus.insn_ready) begin
               insn_count_d = insn_count_q + 32'd1;
               insn_valid_d = 1'b0;
               pc_inc       = 1'b1;
               state_d      = S_WAIT;
            end
         end
         default: state_d = S_WAIT;
      endcase

      // Redirect overrides the FSM but keeps any handshake count; a capture
      // on the same edge is dropped by restoring the held instruction.
      if (bus.redirect_valid) begin
         insn_d       = insn_q;
         insn_pc_d    = insn_pc_q;
         insn_valid_d = 1'b0;
         lat_cnt_d    = '0;
         state_d      = S_WAIT;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_WAIT;
         lat_cnt_q    <= '0;
         insn_q       <= '0;
         insn_pc_q    <= RESET_PC;
         insn_valid_q <= 1'b0;
         insn_count_q <= '0;
      end else begin
         state_q      <= state_d;
         lat_cnt_q    <= lat_cnt_d;
         insn_q       <= insn_d;
         insn_pc_q    <= insn_pc_d;
         insn_valid_q <= insn_valid_d;
         insn_count_q <= insn_count_d;
      end
   end

   assign bus.address_imem  = pc;
   assign bus.insn          = insn_q;
   assign bus.insn_pc       = insn_pc_q;
   assign bus.insn_pc_plus1 = insn_pc_q + ADDR_W'(1);
   assign bus.insn_valid    = insn_valid_q;
   assign insn_count        = insn_count_q;
endmodule
